fp16_mul_pipe: RTL and testbench

FP16_MUL_PIPE -- requirements
Module: fp16_mul_pipe

---
 rtl/fp16_pkg.sv | 31 +++
 rtl/fp16_mul_pipe_if.sv | 22 ++
 rtl/dff.sv | 18 +
 rtl/fp16_mul_core.sv | 108 ++++++++++
 rtl/fp16_mul_pipe.sv | 59 +++++
 tb/tb_fp16_mul_pipe.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 constants, field layout and multiplier intermediate types
package fp16_pkg;

    localparam int          FP16_EXP_BIAS = 15;
    localparam int          FP16_EXP_MAX  = 31;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_PINF     = 16'h7C00;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    typedef enum logic [1:0] {
        KIND_NORM,
        KIND_ZERO,
        KIND_INF,
        KIND_NAN
    } fp16_kind_e;

    // Handoff from the decode/multiply half to the normalise/round half.
    // exp is the unbiased-sum exponent (ea + eb - bias) as a signed byte.
    typedef struct packed {
        fp16_kind_e  kind;
        logic        sign;
        logic [7:0]  exp;
        logic [21:0] prod;
    } fp16_mid_t;

endpackage

// File: rtl/fp16_mul_pipe_if.sv
// rtl/fp16_mul_pipe_if.sv - operand/result handshake bundle for fp16_mul_pipe
interface fp16_mul_pipe_if #(
    parameter int LANES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*LANES-1:0]   input_a;
    logic [16*LANES-1:0]   input_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*LANES-1:0]   result;

    modport master (
        output in_valid, input_a, input_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, input_a, input_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/dff.sv
// rtl/dff.sv - plain register cell with asynchronous active-low reset to a parameterised value
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            q_o <= RESET_VALUE;
        end else begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/fp16_mul_core.sv
// rtl/fp16_mul_core.sv - one FP16 multiply lane: decode/multiply half, staged handoff, normalise/round half
module fp16_mul_core
    import fp16_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic [PIPE_STAGES-1:0] ld_i,
    input  logic [15:0]            a_i,
    input  logic [15:0]            b_i,
    output logic [15:0]            result_o
);
    fp16_t       fa, fb;
    fp16_mid_t   mul_d, rnd_src;
    logic        a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        shift, guard, sticky;
    logic [9:0]  man_t;
    logic [10:0] man_r;
    logic signed [7:0] exp_n, exp_r;
    logic [15:0] rnd_d, res_q;

    // Subnormals decode as zero: only exp==0 is checked, mantissa ignored.
    always_comb begin
        fa     = fp16_t'(a_i);
        fb     = fp16_t'(b_i);
        a_max  = (fa.exp == 5'(FP16_EXP_MAX));
        b_max  = (fb.exp == 5'(FP16_EXP_MAX));
        a_nan  = a_max & (|fa.man);
        b_nan  = b_max & (|fb.man);
        a_inf  = a_max & ~(|fa.man);
        b_inf  = b_max & ~(|fb.man);
        a_zero = (fa.exp == 5'd0);
        b_zero = (fb.exp == 5'd0);
        mul_d      = '0;
        mul_d.sign = fa.sign ^ fb.sign;
        mul_d.exp  = 8'(fa.exp) + 8'(fb.exp) - 8'(FP16_EXP_BIAS);
        mul_d.prod = 22'({1'b1, fa.man}) * 22'({1'b1, fb.man});
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            mul_d.kind = KIND_NAN;
        end else if (a_inf | b_inf) begin
            mul_d.kind = KIND_INF;
        end else if (a_zero | b_zero) begin
            mul_d.kind = KIND_ZERO;
        end else begin
            mul_d.kind = KIND_NORM;
        end
    end

    if (PIPE_STAGES == 1) begin : g_flat
        assign rnd_src = mul_d;
    end else begin : g_split
        fp16_mid_t mid_q [PIPE_STAGES-1];

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                for (int s = 0; s < PIPE_STAGES-1; s++) begin
                    mid_q[s] <= '0;
                end
            end else begin
                if (ld_i[0]) begin
                    mid_q[0] <= mul_d;
                end
                for (int s = 1; s < PIPE_STAGES-1; s++) begin
                    if (ld_i[s]) begin
                        mid_q[s] <= mid_q[s-1];
                    end
                end
            end
        end

        assign rnd_src = mid_q[PIPE_STAGES-2];
    end

    // A mantissa carry out of rounding bumps the exponent; range checks happen after that.
    always_comb begin
        shift  = rnd_src.prod[21];
        man_t  = shift ? rnd_src.prod[20:11] : rnd_src.prod[19:10];
        guard  = shift ? rnd_src.prod[10] : rnd_src.prod[9];
        sticky = shift ? (|rnd_src.prod[9:0]) : (|rnd_src.prod[8:0]);
        man_r  = {1'b0, man_t} + 11'(guard & (sticky | man_t[0]));
        exp_n  = $signed(rnd_src.exp) + (shift ? 8'sd1 : 8'sd0);
        exp_r  = exp_n + (man_r[10] ? 8'sd1 : 8'sd0);
        rnd_d  = {rnd_src.sign, 15'd0};
        case (rnd_src.kind)
            KIND_NAN:  rnd_d = FP16_QNAN;
            KIND_INF:  rnd_d = {rnd_src.sign, FP16_PINF[14:0]};
            KIND_ZERO: rnd_d = {rnd_src.sign, 15'd0};
            default: begin
                if (exp_r >= 8'sd31) begin
                    rnd_d = {rnd_src.sign, FP16_PINF[14:0]};
                end else if (exp_r > 8'sd0) begin
                    rnd_d = {rnd_src.sign, exp_r[4:0], man_r[9:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            res_q <= '0;
        end else if (ld_i[PIPE_STAGES-1]) begin
            res_q <= rnd_d;
        end
    end

    assign result_o = res_q;
endmodule

// File: rtl/fp16_mul_pipe.sv
// rtl/fp16_mul_pipe.sv - multi-lane pipelined FP16 multiplier with a shared valid/ready handshake
module fp16_mul_pipe
    import fp16_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clear,
    fp16_mul_pipe_if.slave   bus
);
    logic [PIPE_STAGES-1:0] vld_q, vld_d, ld;
    logic                   adv;

    // The whole pipe moves as one; it stalls only when the output is occupied and not taken.
    assign adv           = bus.out_ready | ~vld_q[PIPE_STAGES-1];
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[PIPE_STAGES-1];

    always_comb begin
        vld_d = vld_q;
        ld    = '0;
        if (adv) begin
            vld_d[0] = bus.in_valid;
            ld[0]    = bus.in_valid;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                ld[s]    = vld_q[s-1];
            end
        end
        if (clear) begin
            vld_d = '0;
        end
    end

    dff #(
        .WIDTH       (PIPE_STAGES),
        .RESET_VALUE ({PIPE_STAGES{1'b0}})
    ) u_vld (
        .clk     (clk),
        .reset_b (reset_b),
        .d_i     (vld_d),
        .q_o     (vld_q)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp16_mul_core #(
            .PIPE_STAGES (PIPE_STAGES)
        ) u_core (
            .clk      (clk),
            .reset_b  (reset_b),
            .ld_i     (ld),
            .a_i      (bus.input_a[16*g +: 16]),
            .b_i      (bus.input_b[16*g +: 16]),
            .result_o (bus.result[16*g +: 16])
        );
    end
endmodule

// File: tb/tb_fp16_mul_pipe.sv
// tb/tb_fp16_mul_pipe.sv - directed self-checking bench for fp16_mul_pipe (1-lane and 4-lane instances)
module tb_fp16_mul_pipe;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic reset_b;
    logic clear;
    always #5 clk = ~clk;

    fp16_mul_pipe_if #(.LANES(1)) if1 ();
    fp16_mul_pipe_if #(.LANES(4)) if4 ();

    assign if1.in_valid  = if4.in_valid;
    assign if1.out_ready = if4.out_ready;
    assign if1.input_a   = if4.input_a[15:0];
    assign if1.input_b   = if4.input_b[15:0];

    fp16_mul_pipe #(.LANES(1), .PIPE_STAGES(2)) u_dut1 (
        .clk (clk), .reset_b (reset_b), .clear (clear), .bus (if1)
    );
    fp16_mul_pipe #(.LANES(4), .PIPE_STAGES(2)) u_dut4 (
        .clk (clk), .reset_b (reset_b), .clear (clear), .bus (if4)
    );

    logic [15:0] va [NV];
    logic [15:0] vb [NV];
    logic [15:0] vr [NV];
    logic [63:0] exp_q [$];
    logic [10:0] vpat;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    // One cycle: check the output against the scoreboard head at the negedge, then drive.
    task automatic cyc(input logic v, input int vi, input logic ordy, input logic clr);
        logic [63:0] a4, b4, r4;
        @(negedge clk);
        if (if4.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious", 64'(if4.out_valid), 64'd0);
            end else begin
                chk("res4", if4.result, exp_q[0]);
                chk("res1", 64'(if1.result), 64'(exp_q[0][15:0]));
                chk("vld1", 64'(if1.out_valid), 64'd1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            a4[16*k +: 16] = va[(vi + k) % NV];
            b4[16*k +: 16] = vb[(vi + k) % NV];
            r4[16*k +: 16] = vr[(vi + k) % NV];
        end
        if4.input_a   = a4;
        if4.input_b   = b4;
        if4.in_valid  = v;
        if4.out_ready = ordy;
        clear         = clr;
        #1;
        if (if4.out_valid && ordy) begin
            void'(exp_q.pop_front());
        end
        if (clr) begin
            exp_q.delete();
        end else if (v && if4.in_ready) begin
            exp_q.push_back(r4);
        end
    endtask

    initial begin
        va = '{16'h3C00, 16'h3E00, 16'h3C01, 16'h7BFF, 16'hFC00, 16'h7C00, 16'h7E00, 16'h0400,
               16'h8400, 16'h3E01, 16'h3C01, 16'h3C03, 16'h3E00, 16'h7A00, 16'h0400, 16'h0400,
               16'h3C00, 16'hC000, 16'h7C00, 16'h7E01};
        vb = '{16'h3C00, 16'h3E00, 16'h3C01, 16'h4000, 16'h3C00, 16'h0000, 16'h3C00, 16'h0400,
               16'h0400, 16'h3E01, 16'h3E00, 16'h3E00, 16'h3D55, 16'h3D55, 16'h3BFF, 16'h3C00,
               16'h8000, 16'h4200, 16'hC000, 16'h0000};
        vr = '{16'h3C00, 16'h4080, 16'h3C02, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7E00, 16'h0000,
               16'h8000, 16'h4082, 16'h3E02, 16'h3E04, 16'h4000, 16'h7C00, 16'h0000, 16'h0400,
               16'h8000, 16'hC600, 16'hFC00, 16'h7E00};

        reset_b       = 1'b0;
        clear         = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b0;
        if4.input_a   = '0;
        if4.input_b   = '0;
        #1;
        chk("rst_vld4", 64'(if4.out_valid), 64'd0);
        chk("rst_res4", if4.result, 64'd0);
        chk("rst_rdy4", 64'(if4.in_ready), 64'd1);
        chk("rst_rdy1", 64'(if1.in_ready), 64'd1);
        #11;
        reset_b = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0);
            cyc(1'b0, 0, 1'b1, 1'b0);
            chk("lat1_4", 64'(if4.out_valid), 64'd0);
            chk("lat1_1", 64'(if1.out_valid), 64'd0);
            cyc(1'b0, 0, 1'b1, 1'b0);
            chk("lat2_4", 64'(if4.out_valid), 64'd1);
            chk("lat2_1", 64'(if1.out_valid), 64'd1);
        end

        vpat = '0;
        for (int j = 0; j < 11; j++) begin
            cyc(j < 8, j + 3, 1'b1, 1'b0);
            vpat[j] = if4.out_valid;
        end
        chk("b2b_pat", 64'(vpat), 64'(11'b01111111100));
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);

        cyc(1'b1, 5, 1'b1, 1'b0);
        cyc(1'b1, 6, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 7, 1'b0, 1'b0);
            chk("stall_rdy4", 64'(if4.in_ready), 64'd0);
            chk("stall_rdy1", 64'(if1.in_ready), 64'd0);
            chk("stall_vld", 64'(if4.out_valid), 64'd1);
        end
        cyc(1'b1, 7, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        chk("stall_drain", 64'(exp_q.size()), 64'd0);

        cyc(1'b1, 8, 1'b1, 1'b0);
        cyc(1'b1, 9, 1'b1, 1'b0);
        cyc(1'b1, 10, 1'b1, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 0, 1'b1, 1'b0);
            chk("clr_vld4", 64'(if4.out_valid), 64'd0);
            chk("clr_vld1", 64'(if1.out_valid), 64'd0);
        end

        cyc(1'b1, 11, 1'b1, 1'b0);
        cyc(1'b1, 12, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("pre_rst_vld", 64'(if4.out_valid), 64'd1);
        #1;
        reset_b = 1'b0;
        #1;
        chk("mid_rst_vld4", 64'(if4.out_valid), 64'd0);
        chk("mid_rst_vld1", 64'(if1.out_valid), 64'd0);
        chk("mid_rst_res4", if4.result, 64'd0);
        chk("mid_rst_res1", 64'(if1.result), 64'd0);
        chk("mid_rst_rdy", 64'(if4.in_ready), 64'd1);
        #1;
        reset_b = 1'b1;
        exp_q.delete();
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 0, 1'b1, 1'b0);
            chk("post_rst_vld", 64'(if4.out_valid), 64'd0);
        end
        cyc(1'b1, 13, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        chk("post_rst_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
